// File: rtl/bp_pkg.sv
// Shared types and helpers for the BytePipe packet arbiter.
package bp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } state_e;

  localparam logic [3:0] HDR_TAG_DFLT = 4'hA;

  function automatic logic [7:0] hdrByte(input logic [3:0] tag, input logic [2:0] idx);
    return {tag, 1'b0, idx};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request above last_i, wrapping modulo N.
// Zero latency; returns an all-zero grant when nothing requests.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o
);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt_o = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last_i) + k) % N);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bp_pkt_arbiter.sv
// Round-robin packet scheduler: header byte then PKT_LEN payload bytes per grant, 1-cycle arbitration.
// Holds data while ready is low; i_cg=0 freezes state and outputs; flushed packets are zero-padded.
module bp_pkt_arbiter
  import bp_pkg::*;
#(
  parameter int         N_PAIR  = 2,
  parameter int         PKT_LEN = 8,
  parameter logic [3:0] HDR_TAG = HDR_TAG_DFLT
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_cg,
  input  logic [N_PAIR-1:0]   i_enMask,
  input  logic [N_PAIR*8-1:0] i_pktfifo_data,
  input  logic [N_PAIR-1:0]   i_pktfifo_empty,
  input  logic [N_PAIR-1:0]   i_pktfifo_flush,
  output logic [N_PAIR-1:0]   o_pktfifo_pop,
  output logic [7:0]          o_bp_data,
  output logic                o_bp_valid,
  input  logic                i_bp_ready,
  output logic [N_PAIR-1:0]   o_grant,
  output logic                o_busy
);

  localparam int              IW       = (N_PAIR > 1) ? $clog2(N_PAIR) : 1;
  localparam int              CW       = $clog2(PKT_LEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(PKT_LEN - 1);
  localparam logic [IW-1:0]   IDX_RST  = IW'(N_PAIR - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          aborted_q, aborted_d;
  logic          vld_hold_q;
  logic [7:0]    dat_hold_q;

  logic [7:0]        fdata [N_PAIR];
  logic [N_PAIR-1:0] req, pick_gnt;
  logic [IW-1:0]     pick_idx;
  logic              flush_cur, pad, vld_c, xfer, pop_en;
  logic [7:0]        dat_c;

  for (genvar g = 0; g < N_PAIR; g++) begin : g_unpack
    assign fdata[g] = i_pktfifo_data[g*8 +: 8];
  end

  assign req = ~i_pktfifo_empty & i_enMask & ~i_pktfifo_flush;

  rr_arbiter #(.N(N_PAIR), .IW(IW)) u_rr (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (pick_gnt)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_PAIR; i++) begin
      if (pick_gnt[i]) pick_idx = IW'(i);
    end
  end

  // A flush of the owner turns its own cycle into padding so no byte is popped then.
  assign flush_cur = i_pktfifo_flush[idx_q];
  assign pad       = aborted_q | flush_cur;

  always_comb begin
    vld_c = 1'b0;
    dat_c = 8'h00;
    case (state_q)
      HDR: begin
        vld_c = 1'b1;
        dat_c = hdrByte(HDR_TAG, 3'(idx_q));
      end
      PAYLOAD: begin
        vld_c = pad | ~i_pktfifo_empty[idx_q];
        dat_c = pad ? 8'h00 : fdata[idx_q];
      end
      default: ;
    endcase
  end

  assign xfer          = vld_c & i_bp_ready & i_cg;
  assign pop_en        = (state_q == PAYLOAD) & ~pad & xfer;
  assign o_pktfifo_pop = pop_en ? (N_PAIR'(1) << idx_q) : '0;
  assign o_bp_valid    = i_cg ? vld_c : vld_hold_q;
  assign o_bp_data     = i_cg ? dat_c : dat_hold_q;
  assign o_busy        = (state_q != IDLE);
  assign o_grant       = o_busy ? (N_PAIR'(1) << idx_q) : '0;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    aborted_d = aborted_q;
    case (state_q)
      IDLE: begin
        if (|pick_gnt) begin
          idx_d   = pick_idx;
          state_d = HDR;
        end
      end
      HDR: begin
        aborted_d = pad;
        if (xfer) begin
          cnt_d   = '0;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        aborted_d = pad;
        if (xfer) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            state_d   = IDLE;
            last_d    = idx_q;
            aborted_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      last_q     <= IDX_RST;
      cnt_q      <= '0;
      aborted_q  <= 1'b0;
      vld_hold_q <= 1'b0;
      dat_hold_q <= 8'h00;
    end else if (i_cg) begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      aborted_q  <= aborted_d;
      vld_hold_q <= vld_c;
      dat_hold_q <= dat_c;
    end
  end

endmodule

// File: tb/tb_bp_pkt_arbiter.sv
// Directed bench for bp_pkt_arbiter with two modelled packet FIFOs.
module tb_bp_pkt_arbiter;

  logic        clk = 1'b0;
  logic        i_rst_n, i_cg, i_bp_ready;
  logic [1:0]  i_enMask, i_pktfifo_flush;
  logic [15:0] i_pktfifo_data;
  logic [1:0]  i_pktfifo_empty;
  logic [1:0]  o_pktfifo_pop, o_grant;
  logic [7:0]  o_bp_data;
  logic        o_bp_valid, o_busy;

  bp_pkt_arbiter #(.N_PAIR(2), .PKT_LEN(8), .HDR_TAG(4'hA)) dut (
    .i_clk           (clk),
    .i_rst_n         (i_rst_n),
    .i_cg            (i_cg),
    .i_enMask        (i_enMask),
    .i_pktfifo_data  (i_pktfifo_data),
    .i_pktfifo_empty (i_pktfifo_empty),
    .i_pktfifo_flush (i_pktfifo_flush),
    .o_pktfifo_pop   (o_pktfifo_pop),
    .o_bp_data       (o_bp_data),
    .o_bp_valid      (o_bp_valid),
    .i_bp_ready      (i_bp_ready),
    .o_grant         (o_grant),
    .o_busy          (o_busy)
  );

  always #5 clk = ~clk;

  logic [7:0] fmem0 [256];
  logic [7:0] fmem1 [256];
  logic [7:0] rd0 = 8'd0, wr0 = 8'd0, rd1 = 8'd0, wr1 = 8'd0;

  assign i_pktfifo_empty = {rd1 == wr1, rd0 == wr0};
  assign i_pktfifo_data  = {fmem1[rd1], fmem0[rd0]};

  int checks = 0;
  int failures = 0;

  logic       rdy_pat [64];
  logic       cg_pat  [64];
  logic [1:0] fl_pat  [64];
  logic       sv [64];
  logic [7:0] sd [64];
  logic [1:0] sp [64];
  logic       sb [64];
  logic [7:0] xd [64];
  int         xc [64];
  int         nx, pop0, pop1;
  logic [7:0] ex [64];
  int         ne;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int p, input logic [7:0] base);
    for (int k = 0; k < 8; k++) begin
      if (p == 0) begin fmem0[wr0] = base + 8'(k); wr0 = wr0 + 8'd1; end
      else        begin fmem1[wr1] = base + 8'(k); wr1 = wr1 + 8'd1; end
    end
  endtask

  task automatic pats_default();
    for (int c = 0; c < 64; c++) begin
      rdy_pat[c] = 1'b1; cg_pat[c] = 1'b1; fl_pat[c] = 2'b00;
    end
  endtask

  // Called just after a rising edge; records every cycle and applies pops/flushes to the FIFO model.
  task automatic run(input int n);
    nx = 0; pop0 = 0; pop1 = 0;
    for (int c = 0; c < n; c++) begin
      i_bp_ready      = rdy_pat[c];
      i_cg            = cg_pat[c];
      i_pktfifo_flush = fl_pat[c];
      @(negedge clk);
      sv[c] = o_bp_valid; sd[c] = o_bp_data; sp[c] = o_pktfifo_pop; sb[c] = o_busy;
      if (o_bp_valid && i_bp_ready && i_cg) begin
        xd[nx] = o_bp_data; xc[nx] = c; nx++;
      end
      @(posedge clk); #1;
      if (sp[c][0]) begin rd0 = rd0 + 8'd1; pop0++; end
      if (sp[c][1]) begin rd1 = rd1 + 8'd1; pop1++; end
      if (fl_pat[c][0]) rd0 = wr0;
      if (fl_pat[c][1]) rd1 = wr1;
    end
    i_pktfifo_flush = 2'b00;
    i_bp_ready      = 1'b1;
    i_cg            = 1'b1;
    pats_default();
  endtask

  task automatic add(input logic [7:0] b);
    ex[ne] = b; ne++;
  endtask

  task automatic add_pkt(input logic [7:0] hdr, input logic [7:0] base);
    add(hdr);
    for (int k = 0; k < 8; k++) add(base + 8'(k));
  endtask

  task automatic cmp_xfers(input string tag);
    chk({tag, "_count"}, 32'(nx), 32'(ne));
    for (int k = 0; k < ne && k < nx; k++) chk(tag, {24'd0, xd[k]}, {24'd0, ex[k]});
  endtask

  initial begin
    pats_default();
    i_rst_n = 1'b0; i_cg = 1'b1; i_bp_ready = 1'b1;
    i_enMask = 2'b11; i_pktfifo_flush = 2'b00;
    #1;
    chk("rst_valid", 32'(o_bp_valid), 32'd0);
    chk("rst_data",  32'(o_bp_data),  32'd0);
    chk("rst_pop",   32'(o_pktfifo_pop), 32'd0);
    chk("rst_grant", 32'(o_grant),    32'd0);
    chk("rst_busy",  32'(o_busy),     32'd0);
    @(posedge clk); @(posedge clk); #1;
    i_rst_n = 1'b1;

    // 1: single packet from pair 0 after reset
    push(0, 8'h01);
    run(12);
    ne = 0; add_pkt(8'hA0, 8'h01);
    cmp_xfers("t1_byte");
    chk("t1_first_cycle", 32'(xc[0]), 32'd1);
    chk("t1_last_cycle",  32'(xc[8]), 32'd9);
    chk("t1_pop0_count",  32'(pop0), 32'd8);
    chk("t1_hdr_pop",     32'(sp[1]), 32'd0);
    chk("t1_idle_busy",   32'(sb[10]), 32'd0);
    chk("t1_idle_valid",  32'(sv[10]), 32'd0);

    // 2: both pairs pending, round-robin alternation with a single idle cycle between packets
    push(0, 8'h10); push(1, 8'h20); push(1, 8'h40);
    run(30);
    ne = 0; add_pkt(8'hA1, 8'h20); add_pkt(8'hA0, 8'h10); add_pkt(8'hA1, 8'h40);
    cmp_xfers("t2_byte");
    chk("t2_last_cycle", 32'(xc[26]), 32'd29);
    chk("t2_gap_cycle",  32'(sv[10]), 32'd0);

    // 3: ready low for two payload cycles
    push(0, 8'h50);
    rdy_pat[5] = 1'b0; rdy_pat[6] = 1'b0;
    run(13);
    ne = 0; add_pkt(8'hA0, 8'h50);
    cmp_xfers("t3_byte");
    chk("t3_hold5", {23'd0, sv[5], sd[5]}, {23'd0, 1'b1, 8'h53});
    chk("t3_hold6", {23'd0, sv[6], sd[6]}, {23'd0, 1'b1, 8'h53});
    chk("t3_nopop", 32'({sp[5], sp[6]}), 32'd0);
    chk("t3_pop0_count", 32'(pop0), 32'd8);

    // 4: flush of pair 1 after three payload bytes
    push(1, 8'h60); push(0, 8'h70);
    fl_pat[5] = 2'b10;
    run(21);
    ne = 0;
    add(8'hA1); add(8'h60); add(8'h61); add(8'h62);
    for (int k = 0; k < 5; k++) add(8'h00);
    add_pkt(8'hA0, 8'h70);
    cmp_xfers("t4_byte");
    chk("t4_pop1_count", 32'(pop1), 32'd3);
    chk("t4_flush_nopop", 32'(sp[5]), 32'd0);

    // 5: pair 0 masked off
    i_enMask = 2'b10;
    push(0, 8'h80); push(1, 8'h90); push(1, 8'h98);
    run(21);
    ne = 0; add_pkt(8'hA1, 8'h90); add_pkt(8'hA1, 8'h98);
    cmp_xfers("t5_byte");
    chk("t5_pop0_count", 32'(pop0), 32'd0);

    // 6: clock gate low mid-packet, then asynchronous reset during payload
    i_enMask = 2'b11;
    cg_pat[4] = 1'b0; cg_pat[5] = 1'b0; cg_pat[6] = 1'b0; cg_pat[7] = 1'b0;
    run(11);
    ne = 0; add(8'hA0); for (int k = 0; k < 5; k++) add(8'h80 + 8'(k));
    cmp_xfers("t6_byte");
    for (int c = 4; c < 8; c++) begin
      chk("t6_frozen_out", {21'd0, sb[c], sp[c], sv[c], sd[c]}, {21'd0, 1'b1, 2'b00, 1'b1, 8'h81});
    end
    #2 i_rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(o_bp_valid), 32'd0);
    chk("t6_rst_data",  32'(o_bp_data),  32'd0);
    chk("t6_rst_pop",   32'(o_pktfifo_pop), 32'd0);
    chk("t6_rst_grant", 32'(o_grant),    32'd0);
    chk("t6_rst_busy",  32'(o_busy),     32'd0);
    rd0 = wr0;
    push(1, 8'hD0); push(0, 8'hC0);
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    run(4);
    chk("t6_post_hdr",  {23'd0, sv[1], sd[1]}, {23'd0, 1'b1, 8'hA0});
    chk("t6_post_byte", {23'd0, sv[2], sd[2]}, {23'd0, 1'b1, 8'hC0});
    chk("t6_post_pop",  32'(sp[2]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
